f8_cpu: RTL and testbench
=========================

F8_CPU -- requirements
Module: f8_cpu

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h4000: program counter value after reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port iread_addr, output, 16: instruction fetch address, equal to PC.
REQ-005 SHALL have port iread_data, input, 24: bytes PC+0, PC+1, PC+2 in bits [7:0], [15:8], [23:16].
REQ-006 SHALL have port iread_valid, input, 1: iread_data is valid this cycle.
REQ-007 SHALL have port dread_addr, output, 16: data read address; memory returns a combinational little-endian word.
REQ-008 SHALL have port dread_data, input, 16: bytes at dread_addr and dread_addr+1.
REQ-009 SHALL have port dwrite_addr, output, 16: data write address.
REQ-010 SHALL have port dwrite_data, output, 16: write data, with the low byte going to dwrite_addr.
REQ-011 SHALL have port dwrite_en, output, 2: byte enables; bit 0 enables the low byte, bit 1 enables the byte at dwrite_addr+1.
REQ-012 SHALL have port trap, output, 1: core halted on TRAP or an illegal opcode.

Function
REQ-013 SHALL hold architectural state: PC[15:0], XL[7:0], Y[15:0], flags Z, C, N.
REQ-014 SHALL execute one instruction per clock when iread_valid=1 and trap=0.
- Otherwise: no state change, dwrite_en=0.
REQ-015 SHALL decode opcode iread_data[7:0], operand bytes [15:8]/[23:16]; 16-bit operands little-endian; PC advances by instruction length modulo 2^16.
REQ-016 SHALL implement (opcode/length):
- 00/1 TRAP; 01/1 NOP
- 10/2 LD XL,#i8; 12/3 LD XL,(mm); 13/3 LD (mm),XL (dwrite_en=01)
- 20/3 LDW Y,#i16; 22/3 LDW Y,(mm); 23/3 LDW (mm),Y (dwrite_en=11)
REQ-017 SHALL implement ALU ops on XL with 8-bit immediate:
- 30 ADD, 31 SUB, 32 AND, 33 OR, 34 XOR
- 38/3 ADDW Y,#i16
REQ-018 SHALL update flags for ALU ops only:
- Z = result==0; N = result MSB.
- C = carry out (ADD/ADDW); C = borrow (SUB); C unchanged for logic ops.
REQ-019 SHALL implement jumps:
- 40/3 JP #mm.
- 41/2 JRZ d, 42/2 JRNZ d, 43/2 JRC d: target = PC+2+sign-extended d when taken, PC+2 otherwise.
REQ-020 SHALL drive dread_addr and dwrite_* combinationally from the current instruction; memory samples writes on the rising clk edge.
REQ-021 SHALL, on opcode 00 or any undefined opcode, set trap on that clock edge, not advance PC, and halt until reset.
- trap is registered and sticky.

Reset
REQ-022 SHALL, while reset=0, force: PC=RESET_PC, XL=0, Y=0, Z=C=N=0, trap=0, dwrite_en=0.
REQ-023 SHALL abort any in-flight instruction on reset assertion with no write committed; execution resumes on the first valid edge after deassertion.

Configuration
REQ-024 SHALL, with F8_MUL_EN defined, implement 50/1 MUL: Y = XL * Y[7:0] unsigned; Z = Y==0; C = 0.
REQ-025 SHALL, without F8_MUL_EN, treat opcode 50 as illegal (trap).

Structure
REQ-026 SHALL place opcode localparams, flag bit indices and the ALU-op enum in package f8_pkg.
REQ-027 SHALL factor 8/16-bit add, subtract and logic operations into sub-module f8_alu.

Verification
REQ-028 SHALL check: reset released, memory at 4000 = 10 7F 30 01 -> after 2 instructions, XL=80, N=1, C=0, Z=0, PC=4004.
REQ-029 SHALL check: 20 34 12 23 00 80 -> dwrite_addr=8000, dwrite_data=1234, dwrite_en=11; memory then holds 34 at 8000 and 12 at 8001.
REQ-030 SHALL check: XL=05, 31 05, 41 FC -> Z=1; PC returns to the address of the SUB instruction.
REQ-031 SHALL check: opcode FF fetched -> trap rises one clock later; PC, registers and memory frozen; trap stays high until reset.
REQ-032 SHALL check: iread_valid held 0 for 3 cycles mid-program -> no PC or register change and dwrite_en=0 throughout.
REQ-033 SHALL check: with F8_MUL_EN, XL=10, Y=0020, 50 -> Y=0200; without the macro, the same sequence -> trap=1.

Source files
------------

// File: rtl/f8_pkg.sv
// rtl/f8_pkg.sv - opcodes, flag bit indices and ALU operation encoding for the f8 core
package f8_pkg;

  localparam logic [7:0] OP_TRAP    = 8'h00;
  localparam logic [7:0] OP_NOP     = 8'h01;
  localparam logic [7:0] OP_LD_XL_I = 8'h10;
  localparam logic [7:0] OP_LD_XL_M = 8'h12;
  localparam logic [7:0] OP_ST_XL   = 8'h13;
  localparam logic [7:0] OP_LDW_Y_I = 8'h20;
  localparam logic [7:0] OP_LDW_Y_M = 8'h22;
  localparam logic [7:0] OP_ST_Y    = 8'h23;
  localparam logic [7:0] OP_ADD     = 8'h30;
  localparam logic [7:0] OP_SUB     = 8'h31;
  localparam logic [7:0] OP_AND     = 8'h32;
  localparam logic [7:0] OP_OR      = 8'h33;
  localparam logic [7:0] OP_XOR     = 8'h34;
  localparam logic [7:0] OP_ADDW    = 8'h38;
  localparam logic [7:0] OP_JP      = 8'h40;
  localparam logic [7:0] OP_JRZ     = 8'h41;
  localparam logic [7:0] OP_JRNZ    = 8'h42;
  localparam logic [7:0] OP_JRC     = 8'h43;
  localparam logic [7:0] OP_MUL     = 8'h50;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_ADDW
  } alu_op_e;

  typedef enum logic {
    ST_RUN,
    ST_TRAP
  } run_state_e;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/f8_alu.sv
// rtl/f8_alu.sv - 8-bit add/sub/logic and 16-bit add with Z/C/N generation
module f8_alu
  import f8_pkg::*;
(
  input  alu_op_e     op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] result,
  output logic        z,
  output logic        c,
  output logic        n
);

  logic [8:0]  sum8;
  logic [8:0]  diff8;
  logic [16:0] sum16;

  assign sum8  = {1'b0, a[7:0]} + {1'b0, b[7:0]};
  // Bit 8 of the 9-bit difference is the borrow out
  assign diff8 = {1'b0, a[7:0]} - {1'b0, b[7:0]};
  assign sum16 = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = 16'h0000;
    c      = c_in;
    case (op)
      ALU_ADD: begin
        result = {8'h00, sum8[7:0]};
        c      = sum8[8];
      end
      ALU_SUB: begin
        result = {8'h00, diff8[7:0]};
        c      = diff8[8];
      end
      ALU_AND:  result = {8'h00, a[7:0] & b[7:0]};
      ALU_OR:   result = {8'h00, a[7:0] | b[7:0]};
      ALU_XOR:  result = {8'h00, a[7:0] ^ b[7:0]};
      ALU_ADDW: begin
        result = sum16[15:0];
        c      = sum16[16];
      end
      default: begin
        result = 16'h0000;
        c      = c_in;
      end
    endcase
  end

  // Byte results are zero-extended, so a full-width zero test covers both sizes
  assign z = (result == 16'h0000);
  assign n = (op == ALU_ADDW) ? result[15] : result[7];

endmodule

// File: rtl/f8_cpu.sv
// rtl/f8_cpu.sv - single-cycle f8 core; build option F8_MUL_EN adds the MUL instruction
module f8_cpu
  import f8_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h4000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] iread_addr,
  input  logic [23:0] iread_data,
  input  logic        iread_valid,
  output logic [15:0] dread_addr,
  input  logic [15:0] dread_data,
  output logic [15:0] dwrite_addr,
  output logic [15:0] dwrite_data,
  output logic [1:0]  dwrite_en,
  output logic        trap
);

  run_state_e  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  xl_q, xl_d;
  logic [15:0] y_q, y_d;
  logic [2:0]  flags_q, flags_d;

  logic [7:0]  opcode;
  logic [7:0]  op_b1;
  logic [15:0] op_w;
  logic        exec;
  logic [15:0] pc_seq2;
  logic [15:0] br_tgt;

  alu_op_e     alu_op;
  logic        alu_wide;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_res;
  logic        alu_z;
  logic        alu_c;
  logic        alu_n;
  logic [2:0]  alu_flags;

  assign opcode  = iread_data[7:0];
  assign op_b1   = iread_data[15:8];
  assign op_w    = iread_data[23:8];
  assign exec    = iread_valid && (state_q == ST_RUN);
  assign pc_seq2 = pc_q + 16'd2;
  assign br_tgt  = pc_seq2 + sext8(op_b1);

  always_comb begin
    alu_op   = ALU_ADD;
    alu_wide = 1'b0;
    case (opcode)
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_XOR:  alu_op = ALU_XOR;
      OP_ADDW: begin
        alu_op   = ALU_ADDW;
        alu_wide = 1'b1;
      end
      default: alu_op = ALU_ADD;
    endcase
  end

  assign alu_a = alu_wide ? y_q  : {8'h00, xl_q};
  assign alu_b = alu_wide ? op_w : {8'h00, op_b1};

  f8_alu u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .c_in   (flags_q[FLAG_C]),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c),
    .n      (alu_n)
  );

  always_comb begin
    alu_flags         = 3'b000;
    alu_flags[FLAG_Z] = alu_z;
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_N] = alu_n;
  end

`ifdef F8_MUL_EN
  logic [15:0] mul_res;
  assign mul_res = {8'h00, xl_q} * {8'h00, y_q[7:0]};
`endif

  assign iread_addr  = pc_q;
  assign dread_addr  = op_w;
  assign dwrite_addr = op_w;
  assign dwrite_data = (opcode == OP_ST_XL) ? {8'h00, xl_q} : y_q;
  assign trap        = (state_q == ST_TRAP);

  // Reset gates the strobes combinationally so an aborted store never lands
  always_comb begin
    dwrite_en = 2'b00;
    if (exec && reset) begin
      if (opcode == OP_ST_XL) begin
        dwrite_en = 2'b01;
      end else if (opcode == OP_ST_Y) begin
        dwrite_en = 2'b11;
      end
    end
  end

  always_comb begin
    pc_d    = pc_q;
    xl_d    = xl_q;
    y_d     = y_q;
    flags_d = flags_q;
    state_d = state_q;
    if (exec) begin
      case (opcode)
        OP_NOP: pc_d = pc_q + 16'd1;
        OP_LD_XL_I: begin
          xl_d = op_b1;
          pc_d = pc_q + 16'd2;
        end
        OP_LD_XL_M: begin
          xl_d = dread_data[7:0];
          pc_d = pc_q + 16'd3;
        end
        OP_ST_XL, OP_ST_Y: pc_d = pc_q + 16'd3;
        OP_LDW_Y_I: begin
          y_d  = op_w;
          pc_d = pc_q + 16'd3;
        end
        OP_LDW_Y_M: begin
          y_d  = dread_data;
          pc_d = pc_q + 16'd3;
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          xl_d    = alu_res[7:0];
          flags_d = alu_flags;
          pc_d    = pc_q + 16'd2;
        end
        OP_ADDW: begin
          y_d     = alu_res;
          flags_d = alu_flags;
          pc_d    = pc_q + 16'd3;
        end
        OP_JP:   pc_d = op_w;
        OP_JRZ:  pc_d = flags_q[FLAG_Z] ? br_tgt : pc_seq2;
        OP_JRNZ: pc_d = flags_q[FLAG_Z] ? pc_seq2 : br_tgt;
        OP_JRC:  pc_d = flags_q[FLAG_C] ? br_tgt : pc_seq2;
`ifdef F8_MUL_EN
        OP_MUL: begin
          y_d             = mul_res;
          flags_d[FLAG_Z] = (mul_res == 16'h0000);
          flags_d[FLAG_C] = 1'b0;
          flags_d[FLAG_N] = mul_res[15];
          pc_d            = pc_q + 16'd1;
        end
`endif
        OP_TRAP: state_d = ST_TRAP;
        default: state_d = ST_TRAP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      xl_q    <= 8'h00;
      y_q     <= 16'h0000;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      xl_q    <= xl_d;
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_f8_cpu.sv
// tb/tb_f8_cpu.sv - randomized scoreboard bench for f8_cpu against a behavioural model
module tb_f8_cpu;
  import f8_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] iread_addr;
  logic [23:0] iread_data;
  logic        iread_valid;
  logic [15:0] dread_addr;
  logic [15:0] dread_data;
  logic [15:0] dwrite_addr;
  logic [15:0] dwrite_data;
  logic [1:0]  dwrite_en;
  logic        trap;

  always #5 clk = ~clk;

  logic [7:0] mem  [0:65535];
  logic [7:0] mmem [0:65535];

  assign iread_data = {mem[iread_addr + 16'd2], mem[iread_addr + 16'd1], mem[iread_addr]};
  assign dread_data = {mem[dread_addr + 16'd1], mem[dread_addr]};

  f8_cpu dut (
    .clk         (clk),
    .reset       (reset),
    .iread_addr  (iread_addr),
    .iread_data  (iread_data),
    .iread_valid (iread_valid),
    .dread_addr  (dread_addr),
    .dread_data  (dread_data),
    .dwrite_addr (dwrite_addr),
    .dwrite_data (dwrite_data),
    .dwrite_en   (dwrite_en),
    .trap        (trap)
  );

  typedef struct {
    logic [15:0] pc_pre;
    logic [1:0]  we;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic [15:0] pc;
    logic [7:0]  xl;
    logic [15:0] y;
    logic [2:0]  fl;
    logic        trap;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int m_pc, m_xl, m_y;
  bit m_z, m_c, m_n, m_trap;

  logic [1:0]  last_we;
  logic [15:0] last_waddr, last_wdata;

  logic [7:0] op_tab [0:18] = '{8'h01, 8'h10, 8'h12, 8'h13, 8'h20, 8'h22, 8'h23, 8'h30,
                                8'h31, 8'h32, 8'h33, 8'h34, 8'h38, 8'h40, 8'h41, 8'h42,
                                8'h43, 8'h50, 8'h10};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put(input int a, input logic [7:0] v);
    mem[a % 65536]  = v;
    mmem[a % 65536] = v;
  endtask

  function automatic int op_len(input logic [7:0] op);
    case (op)
      8'h01, 8'h50: return 1;
      8'h10, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic gen_program();
    int a;
    int len;
    logic [7:0] op;
    a = 0;
    while (a < 65536) begin
      op = ($urandom_range(0, 299) == 0) ? 8'hFF : op_tab[$urandom_range(0, 18)];
      len = op_len(op);
      put(a, op);
      for (int k = 1; k < len; k++) put(a + k, 8'($urandom_range(0, 255)));
      a += len;
    end
  endtask

  task automatic model_reset();
    m_pc = 'h4000; m_xl = 0; m_y = 0;
    m_z = 0; m_c = 0; m_n = 0; m_trap = 0;
  endtask

  // Behavioural reference: one architectural step over the model's own memory image
  task automatic model_step(input bit v, output exp_t e);
    int op, b1, b2, mm, s, d;
    bit taken;
    e.pc_pre = 16'(m_pc);
    e.we = 2'b00; e.waddr = 16'h0; e.wdata = 16'h0;
    if (v && !m_trap) begin
      op = mmem[m_pc];
      b1 = mmem[(m_pc + 1) % 65536];
      b2 = mmem[(m_pc + 2) % 65536];
      mm = b2 * 256 + b1;
      case (op)
        'h01: m_pc += 1;
        'h10: begin m_xl = b1; m_pc += 2; end
        'h12: begin m_xl = mmem[mm]; m_pc += 3; end
        'h13: begin
          mmem[mm] = 8'(m_xl);
          e.we = 2'b01; e.waddr = 16'(mm); e.wdata = 16'(m_xl);
          m_pc += 3;
        end
        'h20: begin m_y = mm; m_pc += 3; end
        'h22: begin m_y = mmem[mm] + 256 * mmem[(mm + 1) % 65536]; m_pc += 3; end
        'h23: begin
          mmem[mm] = 8'(m_y % 256);
          mmem[(mm + 1) % 65536] = 8'(m_y / 256);
          e.we = 2'b11; e.waddr = 16'(mm); e.wdata = 16'(m_y);
          m_pc += 3;
        end
        'h30, 'h31, 'h32, 'h33, 'h34: begin
          if (op == 'h30) begin s = m_xl + b1; m_c = (s > 255); m_xl = s % 256; end
          else if (op == 'h31) begin m_c = (m_xl < b1); m_xl = (m_xl - b1 + 256) % 256; end
          else if (op == 'h32) m_xl = m_xl & b1;
          else if (op == 'h33) m_xl = m_xl | b1;
          else m_xl = m_xl ^ b1;
          m_z = (m_xl == 0); m_n = (m_xl >= 128);
          m_pc += 2;
        end
        'h38: begin
          s = m_y + mm; m_c = (s > 65535); m_y = s % 65536;
          m_z = (m_y == 0); m_n = (m_y >= 32768);
          m_pc += 3;
        end
        'h40: m_pc = mm;
        'h41, 'h42, 'h43: begin
          taken = (op == 'h41) ? m_z : (op == 'h42) ? !m_z : m_c;
          d = (b1 >= 128) ? b1 - 256 : b1;
          m_pc = m_pc + 2 + (taken ? d : 0);
        end
`ifdef F8_MUL_EN
        'h50: begin
          m_y = m_xl * (m_y % 256);
          m_z = (m_y == 0); m_c = 0; m_n = (m_y >= 32768);
          m_pc += 1;
        end
`endif
        default: m_trap = 1;
      endcase
      m_pc = (m_pc + 65536) % 65536;
    end
    e.pc = 16'(m_pc);
    e.xl = 8'(m_xl);
    e.y  = 16'(m_y);
    e.fl = 3'b000;
    e.fl[FLAG_Z] = m_z;
    e.fl[FLAG_C] = m_c;
    e.fl[FLAG_N] = m_n;
    e.trap = m_trap;
  endtask

  task automatic cycle(input bit v);
    exp_t e;
    @(negedge clk);
    iread_valid = v;
    model_step(v, e);
    sb_q.push_back(e);
    #4;
    last_we = dwrite_en; last_waddr = dwrite_addr; last_wdata = dwrite_data;
    @(posedge clk);
    #1;
    if (last_we[0]) mem[last_waddr] = last_wdata[7:0];
    if (last_we[1]) mem[last_waddr + 16'd1] = last_wdata[15:8];
    #2;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    iread_valid = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_pc", iread_addr, 16'h4000);
    chk("rst_xl", dut.xl_q, 8'h00);
    chk("rst_y", dut.y_q, 16'h0000);
    chk("rst_flags", dut.flags_q, 3'b000);
    chk("rst_trap", trap, 1'b0);
    chk("rst_we", dwrite_en, 2'b00);
    @(negedge clk);
    iread_valid = 1'b0;
    reset = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("iread_addr", iread_addr, e.pc_pre);
        chk("dwrite_en", dwrite_en, e.we);
        if (e.we != 2'b00) begin
          chk("dwrite_addr", dwrite_addr, e.waddr);
          if (e.we == 2'b11) chk("dwrite_data", dwrite_data, e.wdata);
          else chk("dwrite_data_lo", dwrite_data[7:0], e.wdata[7:0]);
        end
        @(posedge clk);
        #2;
        chk("pc", dut.pc_q, e.pc);
        chk("xl", dut.xl_q, e.xl);
        chk("y", dut.y_q, e.y);
        chk("flags", dut.flags_q, e.fl);
        chk("trap", trap, e.trap);
        if (e.we[0]) chk("mem_lo", mem[e.waddr], e.wdata[7:0]);
        if (e.we[1]) chk("mem_hi", mem[e.waddr + 16'd1], e.wdata[15:8]);
      end
    end
  end

  initial begin : driver
    reset = 1'b0;
    iread_valid = 1'b0;
    last_we = 2'b00; last_waddr = 16'h0; last_wdata = 16'h0;
    gen_program();

    // Two instructions: load 7F then add 1 overflows into the sign bit
    apply_reset();
    put('h4000, 8'h10); put('h4001, 8'h7F); put('h4002, 8'h30); put('h4003, 8'h01);
    cycle(1); cycle(1);
    chk("d1_xl", dut.xl_q, 8'h80);
    chk("d1_n", dut.flags_q[FLAG_N], 1'b1);
    chk("d1_c", dut.flags_q[FLAG_C], 1'b0);
    chk("d1_z", dut.flags_q[FLAG_Z], 1'b0);
    chk("d1_pc", dut.pc_q, 16'h4004);

    apply_reset();
    put('h4000, 8'h20); put('h4001, 8'h34); put('h4002, 8'h12);
    put('h4003, 8'h23); put('h4004, 8'h00); put('h4005, 8'h80);
    cycle(1); cycle(1);
    chk("d2_we", last_we, 2'b11);
    chk("d2_waddr", last_waddr, 16'h8000);
    chk("d2_wdata", last_wdata, 16'h1234);
    chk("d2_mem8000", mem['h8000], 8'h34);
    chk("d2_mem8001", mem['h8001], 8'h12);

    apply_reset();
    put('h4000, 8'h10); put('h4001, 8'h05); put('h4002, 8'h31);
    put('h4003, 8'h05); put('h4004, 8'h41); put('h4005, 8'hFC);
    cycle(1); cycle(1); cycle(1);
    chk("d3_z", dut.flags_q[FLAG_Z], 1'b1);
    chk("d3_pc", dut.pc_q, 16'h4002);

    apply_reset();
    put('h4000, 8'h01); put('h4001, 8'hFF);
    cycle(1); cycle(1);
    chk("d4_trap", trap, 1'b1);
    chk("d4_pc", dut.pc_q, 16'h4001);
    repeat (3) cycle(1);
    chk("d4_trap_sticky", trap, 1'b1);
    chk("d4_pc_frozen", dut.pc_q, 16'h4001);

    apply_reset();
    put('h4000, 8'h10); put('h4001, 8'h11);
    put('h4002, 8'h13); put('h4003, 8'h00); put('h4004, 8'h90);
    put('h4005, 8'h30); put('h4006, 8'h22);
    put('h9000, 8'h00);
    cycle(1);
    repeat (3) begin
      cycle(0);
      chk("d5_stall_pc", dut.pc_q, 16'h4002);
      chk("d5_stall_we", last_we, 2'b00);
      chk("d5_stall_xl", dut.xl_q, 8'h11);
    end
    cycle(1);
    chk("d5_we", last_we, 2'b01);
    chk("d5_mem9000", mem['h9000], 8'h11);
    cycle(1);
    chk("d5_xl", dut.xl_q, 8'h33);

    apply_reset();
    put('h4000, 8'h10); put('h4001, 8'h10);
    put('h4002, 8'h20); put('h4003, 8'h20); put('h4004, 8'h00);
    put('h4005, 8'h50);
    cycle(1); cycle(1); cycle(1);
`ifdef F8_MUL_EN
    chk("d6_y", dut.y_q, 16'h0200);
    chk("d6_trap", trap, 1'b0);
`else
    chk("d6_trap", trap, 1'b1);
    chk("d6_pc", dut.pc_q, 16'h4005);
`endif

    // Reset asserted mid-cycle under a pending store must suppress the write
    apply_reset();
    put('h4000, 8'h10); put('h4001, 8'hAA);
    put('h4002, 8'h13); put('h4003, 8'h00); put('h4004, 8'hA0);
    put('hA000, 8'h55);
    cycle(1);
    @(negedge clk);
    iread_valid = 1'b1;
    #1;
    chk("d7_we_pre", dwrite_en, 2'b01);
    #1;
    reset = 1'b0;
    #2;
    chk("d7_we_abort", dwrite_en, 2'b00);
    @(posedge clk);
    #2;
    chk("d7_mem", mem['hA000], 8'h55);
    chk("d7_pc", dut.pc_q, 16'h4000);
    chk("d7_xl", dut.xl_q, 8'h00);
    iread_valid = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    put('h4000, 8'h10); put('h4001, 8'h3C);
    cycle(1);
    chk("d7_resume_xl", dut.xl_q, 8'h3C);

    for (int r = 0; r < 16; r++) begin
      gen_program();
      apply_reset();
      for (int i = 0; i < 200; i++) begin
        cycle($urandom_range(0, 9) < 8);
        if (m_trap) begin
          repeat (3) cycle(1);
          break;
        end
      end
    end

    iread_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
